// File: rtl/ref_pulse_sched_pkg.sv
// Shared definitions for the reference-pulse scheduler: FSM states and default sizes.
package ref_pulse_sched_pkg;

  localparam int unsigned NchDefault = 4;
  localparam int unsigned CwDefault  = 24;
  localparam int unsigned PwDefault  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StMeasure,
    StReport,
    StNext
  } state_e;

endpackage

// File: rtl/ref_pulse_sched_rr_next_ch.sv
// Round-robin search: first set mask bit strictly after cur, wrapping around (cur itself last).
module rr_next_ch
  import ref_pulse_sched_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  parameter int unsigned SW  = $clog2(NCH)
) (
  input  logic [SW-1:0]  cur,
  input  logic [NCH-1:0] mask,
  output logic [SW-1:0]  nxt,
  output logic           none
);

  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;

  always_comb begin
    int sum;
    sum  = 0;
    dbl  = {mask, mask};
    // rot[k] is the mask bit of channel (cur + 1 + k) mod NCH
    rot  = NCH'(dbl >> (int'(cur) + 1));
    nxt  = cur;
    none = (mask == '0);
    // Walk downward so the nearest candidate is the last one assigned.
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = int'(cur) + 1 + k;
        if (sum >= int'(NCH)) begin
          sum = sum - int'(NCH);
        end
        nxt = SW'(sum);
      end
    end
  end

endmodule

// File: rtl/ref_pulse_sched.sv
// Round-robin reference-pulse interval scheduler: arms each unmasked channel in turn,
// counts MCLK cycles over NPULSE pulse intervals (or times out) and hands off the result.
module ref_pulse_sched
  import ref_pulse_sched_pkg::*;
#(
  parameter int unsigned NCH = NchDefault,
  parameter int unsigned CW  = CwDefault,
  parameter int unsigned PW  = PwDefault,
  parameter int unsigned SW  = $clog2(NCH)
) (
  input  logic           MCLK,
  input  logic           RST,
  input  logic [NCH-1:0] CNT_IN,
  input  logic           EN,
  input  logic [NCH-1:0] CH_MASK,
  input  logic [PW-1:0]  NPULSE,
  input  logic [CW-1:0]  TIMEOUT,
  output logic [SW-1:0]  CH_SEL,
  output logic           BUSY,
  output logic           RES_VALID,
  input  logic           RES_READY,
  output logic [CW-1:0]  RESULT,
  output logic [SW-1:0]  RES_CH,
  output logic           RES_TIMEOUT
);

  state_e        state;
  logic [CW-1:0] cyc, tmr, to_lat;
  logic [PW-1:0] pcnt, np_lat;

  logic [CW-1:0] cyc_inc, tmr_inc;
  logic [PW-1:0] pcnt_inc, np_eff;
  logic [SW-1:0] rr_cur, rr_nxt;
  logic          rr_none;
  logic          pulse, go, to_hit, terminal;

  assign pulse    = CNT_IN[CH_SEL];
  assign go       = EN && (CH_MASK != '0);
  assign cyc_inc  = (cyc == '1) ? cyc : cyc + 1'b1;
  assign tmr_inc  = (tmr == '1) ? tmr : tmr + 1'b1;
  assign pcnt_inc = pcnt + 1'b1;
  assign np_eff   = (np_lat == '0) ? PW'(1) : np_lat;
  assign to_hit   = (to_lat != '0) && (tmr_inc == to_lat);
  assign terminal = pulse && (pcnt_inc >= np_eff);
  assign BUSY     = (state != StIdle);

  // From IDLE the search is inclusive of CH_SEL, so start one channel earlier.
  assign rr_cur = (state != StIdle) ? CH_SEL :
                  (CH_SEL == '0)    ? SW'(NCH - 1) : CH_SEL - 1'b1;

  rr_next_ch #(
    .NCH (NCH),
    .SW  (SW)
  ) u_rr (
    .cur  (rr_cur),
    .mask (CH_MASK),
    .nxt  (rr_nxt),
    .none (rr_none)
  );

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state       <= StIdle;
      CH_SEL      <= '0;
      RES_VALID   <= 1'b0;
      RESULT      <= '0;
      RES_CH      <= '0;
      RES_TIMEOUT <= 1'b0;
      cyc         <= '0;
      tmr         <= '0;
      pcnt        <= '0;
      to_lat      <= '0;
      np_lat      <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (go) begin
            state  <= StArm;
            CH_SEL <= rr_nxt;
            tmr    <= '0;
            np_lat <= NPULSE;
            to_lat <= TIMEOUT;
          end
        end
        StArm: begin
          if (!EN) begin
            state <= StIdle;
          end else begin
            tmr <= tmr_inc;
            if (to_hit) begin
              state       <= StReport;
              RES_VALID   <= 1'b1;
              RESULT      <= '0;
              RES_CH      <= CH_SEL;
              RES_TIMEOUT <= 1'b1;
            end else if (pulse) begin
              state <= StMeasure;
              cyc   <= '0;
              pcnt  <= '0;
            end
          end
        end
        StMeasure: begin
          if (!EN) begin
            state <= StIdle;
          end else begin
            tmr <= tmr_inc;
            cyc <= cyc_inc;
            if (pulse) begin
              pcnt <= pcnt_inc;
            end
            // Terminal pulse takes priority over a timeout in the same cycle.
            if (terminal) begin
              state       <= StReport;
              RES_VALID   <= 1'b1;
              RESULT      <= cyc_inc;
              RES_CH      <= CH_SEL;
              RES_TIMEOUT <= 1'b0;
            end else if (to_hit) begin
              state       <= StReport;
              RES_VALID   <= 1'b1;
              RESULT      <= '0;
              RES_CH      <= CH_SEL;
              RES_TIMEOUT <= 1'b1;
            end
          end
        end
        StReport: begin
          if (RES_READY) begin
            RES_VALID <= 1'b0;
            state     <= StNext;
          end
        end
        StNext: begin
          if (!rr_none) begin
            CH_SEL <= rr_nxt;
          end
          if (go) begin
            state  <= StArm;
            tmr    <= '0;
            np_lat <= NPULSE;
            to_lat <= TIMEOUT;
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_pulse_sched.sv
// Directed bench for ref_pulse_sched: inputs driven and outputs sampled on the falling edge.
module tb_ref_pulse_sched;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  cnt_in = '0;
  logic        en = 1'b0;
  logic [3:0]  ch_mask = 4'b1111;
  logic [7:0]  npulse = 8'd1;
  logic [23:0] timeout = '0;
  logic [1:0]  ch_sel;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [23:0] result;
  logic [1:0]  res_ch;
  logic        res_timeout;

  int n_pass  = 0;
  int n_total = 0;
  int exp_ch [6] = '{1, 3, 1, 3, 2, 2};

  always #5 mclk = ~mclk;

  ref_pulse_sched #(
    .NCH (4),
    .CW  (24),
    .PW  (8)
  ) dut (
    .MCLK        (mclk),
    .RST         (rst),
    .CNT_IN      (cnt_in),
    .EN          (en),
    .CH_MASK     (ch_mask),
    .NPULSE      (npulse),
    .TIMEOUT     (timeout),
    .CH_SEL      (ch_sel),
    .BUSY        (busy),
    .RES_VALID   (res_valid),
    .RES_READY   (res_ready),
    .RESULT      (result),
    .RES_CH      (res_ch),
    .RES_TIMEOUT (res_timeout)
  );

  task automatic tick();
    @(negedge mclk);
  endtask

  task automatic do_pulse(input int ch);
    cnt_in = 4'b0001 << ch;
    tick();
    cnt_in = '0;
  endtask

  task automatic test_reset();
    tick();
    n_total++;
    if ({busy, res_valid, result, res_ch, res_timeout, ch_sel} !== 31'd0)
      $display("FAIL reset_state: got %0h expected 0",
               {busy, res_valid, result, res_ch, res_timeout, ch_sel});
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_when_disabled: busy got %0b expected 0", busy);
    else n_pass++;
  endtask

  // Ch0 pulses 10 cycles apart, NPULSE=1 -> RESULT=10; next arm on ch1.
  task automatic test_basic();
    en = 1'b1;
    tick();
    n_total++;
    if ({busy, ch_sel} !== {1'b1, 2'd0})
      $display("FAIL basic_arm: got %0h expected %0h", {busy, ch_sel}, {1'b1, 2'd0});
    else n_pass++;
    do_pulse(0);
    repeat (9) tick();
    do_pulse(0);
    n_total++;
    if ({res_valid, result, res_ch, res_timeout} !== {1'b1, 24'd10, 2'd0, 1'b0})
      $display("FAIL basic_result: got %0h expected %0h",
               {res_valid, result, res_ch, res_timeout}, {1'b1, 24'd10, 2'd0, 1'b0});
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL basic_valid_fall: got %0b expected 0", res_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({busy, ch_sel} !== {1'b1, 2'd1})
      $display("FAIL basic_next_arm: got %0h expected %0h", {busy, ch_sel}, {1'b1, 2'd1});
    else n_pass++;
  endtask

  // NPULSE=3 with 7-cycle spacing -> 21; also latch, ignored channels, backpressure, EN=0 in REPORT.
  task automatic test_npulse_backpressure();
    en = 1'b0;
    tick();
    npulse = 8'd3;
    en = 1'b1;
    tick();
    npulse = 8'd1;
    n_total++;
    if (ch_sel !== 2'd1) $display("FAIL np_arm_ch: got %0d expected 1", ch_sel);
    else n_pass++;
    do_pulse(1);
    repeat (6) tick();
    do_pulse(1);
    do_pulse(2);
    repeat (5) tick();
    do_pulse(1);
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL np_early_report: got %0b expected 0", res_valid);
    else n_pass++;
    repeat (6) tick();
    do_pulse(1);
    n_total++;
    if ({res_valid, result, res_ch, res_timeout} !== {1'b1, 24'd21, 2'd1, 1'b0})
      $display("FAIL np_result: got %0h expected %0h",
               {res_valid, result, res_ch, res_timeout}, {1'b1, 24'd21, 2'd1, 1'b0});
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      en = i[0];
      cnt_in = (i % 3 == 0) ? 4'b0010 : 4'b0000;
      tick();
      n_total++;
      if ({busy, res_valid, result, res_ch, res_timeout, ch_sel} !==
          {1'b1, 1'b1, 24'd21, 2'd1, 1'b0, 2'd1})
        $display("FAIL hold_cycle_%0d: got %0h expected %0h", i,
                 {busy, res_valid, result, res_ch, res_timeout, ch_sel},
                 {1'b1, 1'b1, 24'd21, 2'd1, 1'b0, 2'd1});
      else n_pass++;
    end
    cnt_in = '0;
    en = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    n_total++;
    if ({busy, res_valid, ch_sel} !== {1'b0, 1'b0, 2'd2})
      $display("FAIL next_to_idle: got %0h expected %0h",
               {busy, res_valid, ch_sel}, {1'b0, 1'b0, 2'd2});
    else n_pass++;
  endtask

  // TIMEOUT=50 with only foreign-channel pulses -> timeout report 50 cycles after arm.
  task automatic test_timeout();
    timeout = 24'd50;
    en = 1'b1;
    cnt_in = 4'b1011;
    tick();
    timeout = '0;
    n_total++;
    if (ch_sel !== 2'd2) $display("FAIL to_arm_ch: got %0d expected 2", ch_sel);
    else n_pass++;
    repeat (49) tick();
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL to_early: got %0b expected 0", res_valid);
    else n_pass++;
    tick();
    cnt_in = '0;
    n_total++;
    if ({res_valid, res_timeout, result, res_ch} !== {1'b1, 1'b1, 24'd0, 2'd2})
      $display("FAIL to_report: got %0h expected %0h",
               {res_valid, res_timeout, result, res_ch}, {1'b1, 1'b1, 24'd0, 2'd2});
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    n_total++;
    if ({busy, ch_sel} !== {1'b1, 2'd3})
      $display("FAIL to_next_arm: got %0h expected %0h", {busy, ch_sel}, {1'b1, 2'd3});
    else n_pass++;
  endtask

  // Terminal pulse on the same edge the 10-cycle timeout expires.
  task automatic test_coincide();
    en = 1'b0;
    tick();
    timeout = 24'd10;
    npulse = 8'd1;
    en = 1'b1;
    tick();
    do_pulse(3);
    repeat (8) tick();
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL co_early: got %0b expected 0", res_valid);
    else n_pass++;
    do_pulse(3);
    n_total++;
    if ({res_valid, res_timeout, result, res_ch} !== {1'b1, 1'b0, 24'd9, 2'd3})
      $display("FAIL co_report: got %0h expected %0h",
               {res_valid, res_timeout, result, res_ch}, {1'b1, 1'b0, 24'd9, 2'd3});
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    n_total++;
    if (ch_sel !== 2'd0) $display("FAIL co_wrap: got %0d expected 0", ch_sel);
    else n_pass++;
  endtask

  // Mask 1010 visits 1,3,1,3; then a lone channel 2 is re-armed twice.
  task automatic test_rotation();
    en = 1'b0;
    tick();
    ch_mask = 4'b1010;
    timeout = 24'd3;
    en = 1'b1;
    tick();
    n_total++;
    if (ch_sel !== 2'd1) $display("FAIL rot_first: got %0d expected 1", ch_sel);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      bit got;
      got = 1'b0;
      if (i == 4) ch_mask = 4'b0100;
      for (int c = 0; c < 20 && !got; c++) begin
        tick();
        if (res_valid) got = 1'b1;
      end
      n_total++;
      if (got !== 1'b1) $display("FAIL rot_wait_%0d: got no report expected report", i);
      else n_pass++;
      n_total++;
      if (res_ch !== 2'(exp_ch[i]))
        $display("FAIL rot_ch_%0d: got %0d expected %0d", i, res_ch, exp_ch[i]);
      else n_pass++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
  endtask

  // EN dropped mid-measurement -> IDLE with no report.
  task automatic test_abort();
    en = 1'b0;
    tick();
    ch_mask = 4'b1111;
    timeout = '0;
    npulse = 8'd2;
    en = 1'b1;
    tick();
    do_pulse(2);
    repeat (3) tick();
    en = 1'b0;
    tick();
    n_total++;
    if ({busy, res_valid} !== 2'b00)
      $display("FAIL abort_idle: got %0b expected 00", {busy, res_valid});
    else n_pass++;
    for (int i = 0; i < 5; i++) do_pulse(2);
    n_total++;
    if ({busy, res_valid} !== 2'b00)
      $display("FAIL abort_no_report: got %0b expected 00", {busy, res_valid});
    else n_pass++;
  endtask

  // Asynchronous reset during REPORT clears everything before the next edge.
  task automatic test_reset_in_report();
    npulse = 8'd1;
    en = 1'b1;
    tick();
    do_pulse(2);
    repeat (3) tick();
    do_pulse(2);
    n_total++;
    if ({res_valid, result, res_ch} !== {1'b1, 24'd4, 2'd2})
      $display("FAIL rr_report: got %0h expected %0h",
               {res_valid, result, res_ch}, {1'b1, 24'd4, 2'd2});
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({busy, res_valid, result, res_ch, res_timeout, ch_sel} !== 31'd0)
      $display("FAIL async_reset: got %0h expected 0",
               {busy, res_valid, result, res_ch, res_timeout, ch_sel});
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if ({busy, res_valid, ch_sel} !== {1'b1, 1'b0, 2'd0})
      $display("FAIL resume_after_reset: got %0h expected %0h",
               {busy, res_valid, ch_sel}, {1'b1, 1'b0, 2'd0});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_npulse_backpressure();
    test_timeout();
    test_coincide();
    test_rotation();
    test_abort();
    test_reset_in_report();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
